// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the UART receiver and transmitter on the
// echo path. Buffers single-cycle receive strobes and replays the bytes in
// order through the transmitter's send_data / send_data_complete handshake.
// A write arriving while full is dropped and raises the sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  send_data,
  input  logic                  send_data_complete,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  load;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot at the same edge, so a write into a full FIFO is
  // still accepted when the transmitter completes at that edge.
  assign push = wr_valid && (!full || pop);
  assign drop = wr_valid && !push;

  // Transmit FSM next-state: load on leaving IDLE, pop on leaving SEND.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = LOAD;
          load      = 1'b1;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (send_data_complete) begin
          state_nxt = GAP;
          pop       = 1'b1;
        end
      end
      GAP: begin
        if (!send_data_complete) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; send_data is registered from the next state so it is
  // high exactly while the FSM sits in SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      send_data <= 1'b0;
    end else begin
      state     <= state_nxt;
      send_data <= (state_nxt == SEND);
    end
  end

  // Byte presented to the transmitter, captured only on IDLE->LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data <= '0;
    end else if (load) begin
      tx_data <= mem[rd_ptr];
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop at the same edge wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
